ram_scan_reader: RTL and testbench

RAM_SCAN_READER -- requirements
Module: ram_scan_reader

---
 rtl/ram_scan_reader.sv | 153 +++++++++++++++
 tb/tb_ram_scan_reader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// Steps a read address through a RAM once every TICK_DIV cycles and captures each word for display.
// Optional feature: define RAM_SCAN_READER_STEP_EN to add a single-step input usable while frozen.
module ram_scan_reader #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 3,
    parameter int TICK_DIV = 50_000_000,
    parameter int RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
`ifdef RAM_SCAN_READER_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]  ISSUE_LAST = CNT_W'(RD_LAT - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST  = CNT_W'(TICK_DIV - RD_LAT - 2);
    localparam logic [ADDR_W-1:0] ADDR_MAX   = '1;

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]   disp_addr_q, disp_addr_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic                disp_valid_q, disp_valid_d;
    logic                wrap_q, wrap_d;
    logic                active;

`ifdef RAM_SCAN_READER_STEP_EN
    logic step_prev_q, step_prev_d;
    logic step_run_q, step_run_d;
    logic step_rise;

    assign step_rise = step & ~step_prev_q;
    // A single-step read must finish even though enable is low.
    assign active    = enable | step_run_q;
`else
    assign active    = enable;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        rd_addr_d    = rd_addr_q;
        disp_addr_d  = disp_addr_q;
        disp_data_d  = disp_data_q;
        disp_valid_d = disp_valid_q;
        wrap_d       = 1'b0;
`ifdef RAM_SCAN_READER_STEP_EN
        step_prev_d  = step;
        step_run_d   = step_run_q;
`endif
        if (!active) begin
            state_d = IDLE;
            cnt_d   = '0;
`ifdef RAM_SCAN_READER_STEP_EN
            if (step_rise) begin
                rd_addr_d  = rd_addr_q + ADDR_W'(1);
                wrap_d     = (rd_addr_q == ADDR_MAX);
                state_d    = ISSUE;
                step_run_d = 1'b1;
            end
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ISSUE;
                    cnt_d   = '0;
                end
                ISSUE: begin
                    if (cnt_q == ISSUE_LAST) begin
                        state_d = CAPTURE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                CAPTURE: begin
                    disp_data_d  = rd_data;
                    disp_addr_d  = rd_addr_q;
                    disp_valid_d = 1'b1;
                    cnt_d        = '0;
                    state_d      = HOLD;
`ifdef RAM_SCAN_READER_STEP_EN
                    if (step_run_q) begin
                        state_d    = IDLE;
                        step_run_d = 1'b0;
                    end
`endif
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        wrap_d    = (rd_addr_q == ADDR_MAX);
                        state_d   = ISSUE;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_addr_q    <= '0;
            disp_addr_q  <= '0;
            disp_data_q  <= '0;
            disp_valid_q <= 1'b0;
            wrap_q       <= 1'b0;
`ifdef RAM_SCAN_READER_STEP_EN
            step_prev_q  <= 1'b0;
            step_run_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_addr_q    <= rd_addr_d;
            disp_addr_q  <= disp_addr_d;
            disp_data_q  <= disp_data_d;
            disp_valid_q <= disp_valid_d;
            wrap_q       <= wrap_d;
`ifdef RAM_SCAN_READER_STEP_EN
            step_prev_q  <= step_prev_d;
            step_run_q   <= step_run_d;
`endif
        end
    end

    assign rd_addr    = rd_addr_q;
    assign disp_addr  = disp_addr_q;
    assign disp_data  = disp_data_q;
    assign disp_valid = disp_valid_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Bench for ram_scan_reader with TICK_DIV=4, RD_LAT=1 and a RAM holding mem[a] = a[2:0].
module tb_ram_scan_reader;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [4:0] rd_addr;
    logic [2:0] rd_data = 3'd0;
    logic [4:0] disp_addr;
    logic [2:0] disp_data;
    logic       disp_valid;
    logic       wrap;
`ifdef RAM_SCAN_READER_STEP_EN
    logic       step = 1'b0;
`endif

    ram_scan_reader #(.ADDR_W(5), .DATA_W(3), .TICK_DIV(4), .RD_LAT(1)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
`ifdef RAM_SCAN_READER_STEP_EN
        .step(step),
`endif
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .disp_addr(disp_addr),
        .disp_data(disp_data),
        .disp_valid(disp_valid),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Registered-output RAM model
    always_ff @(posedge clk) rd_data <= rd_addr[2:0];

    typedef struct {
        logic       en;
        logic [4:0] rd;
        logic [4:0] da;
        logic [2:0] dd;
        logic       dv;
        logic       wr;
    } vec_t;

    typedef struct {
        logic [4:0] a;
        logic [2:0] d;
        int         t;
    } sb_t;

    vec_t       tbl[12];
    sb_t        sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         wrap_cnt = 0;
    int         caps = 0;
    logic       sb_on = 1'b0;
    logic [4:0] prev_rd = 5'd0;
    logic [4:0] prev_da = 5'd0;
    logic [2:0] prev_dd = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] pack(input int rd, input int da, input int dd, input int dv, input int wr);
        return {17'd0, 5'(rd), 5'(da), 3'(dd), 1'(dv), 1'(wr)};
    endfunction

    function automatic logic [31:0] cur();
        return {17'd0, rd_addr, disp_addr, disp_data, disp_valid, wrap};
    endfunction

    function automatic vec_t mkv(input int rd, input int da, input int dd, input int dv);
        vec_t v;
        v.en = 1'b1;
        v.rd = 5'(rd);
        v.da = 5'(da);
        v.dd = 3'(dd);
        v.dv = 1'(dv);
        v.wr = 1'b0;
        return v;
    endfunction

    task automatic sb_step();
        sb_t e;
        if (rd_addr != prev_rd) begin
            e.a = rd_addr;
            e.d = rd_addr[2:0];
            e.t = cyc;
            sbq.push_back(e);
        end
        chk("sb_wrap", 32'(wrap), 32'(prev_rd == 5'd31 && rd_addr == 5'd0));
        if (wrap) wrap_cnt++;
        if (disp_addr != prev_da || disp_data != prev_dd) begin
            caps++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: capture of addr %0d with no read pending", disp_addr);
            end else begin
                e = sbq.pop_front();
                chk("sb_addr", 32'(disp_addr), 32'(e.a));
                chk("sb_data", 32'(disp_data), 32'(e.d));
                chk("sb_latency", 32'(cyc - e.t), 32'd2);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (sb_on) sb_step();
        prev_rd = rd_addr;
        prev_da = disp_addr;
        prev_dd = disp_data;
    endtask

    task automatic wait_rd(input logic [4:0] target);
        int n;
        n = 0;
        while (rd_addr !== target && n < 400) begin
            tick();
            n++;
        end
        chk("wait_rd", 32'(rd_addr), 32'(target));
    endtask

    // Releases reset with enable high and checks the first three scan periods cycle by cycle.
    task automatic run_table();
        enable = tbl[0].en;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            enable = tbl[i].en;
            tick();
            chk($sformatf("tbl_row%0d", i), cur(),
                pack(tbl[i].rd, tbl[i].da, tbl[i].dd, tbl[i].dv, tbl[i].wr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mkv(0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0);
        tbl[2]  = mkv(0, 0, 0, 1);
        tbl[3]  = mkv(0, 0, 0, 1);
        tbl[4]  = mkv(1, 0, 0, 1);
        tbl[5]  = mkv(1, 0, 0, 1);
        tbl[6]  = mkv(1, 1, 1, 1);
        tbl[7]  = mkv(1, 1, 1, 1);
        tbl[8]  = mkv(2, 1, 1, 1);
        tbl[9]  = mkv(2, 1, 1, 1);
        tbl[10] = mkv(2, 2, 2, 1);
        tbl[11] = mkv(2, 2, 2, 1);

        repeat (3) tick();
        chk("reset_state", cur(), pack(0, 0, 0, 0, 0));

        run_table();

        // Continuous scan through a full wrap, checked by the scoreboard.
        sb_on = 1'b1;
        repeat (131) tick();
        sb_on = 1'b0;
        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("sb_wrap_count", 32'(wrap_cnt), 32'd1);
        chk("sb_capture_count", 32'(caps), 32'd33);

        // Freeze during CAPTURE of address 5, then re-enable.
        wait_rd(5'd5);
        tick();
        enable = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("freeze_hold", cur(), pack(5, 4, 4, 1, 0));
        end
        enable = 1'b1;
        tick();
        tick();
        tick();
        chk("reread_capture", cur(), pack(5, 5, 5, 1, 0));
        tick();
        chk("reread_addr_held", 32'(rd_addr), 32'd5);
        tick();
        chk("reread_then_advance", 32'(rd_addr), 32'd6);

        // Enable drops in the HOLD-expiry cycle at address 31.
        wait_rd(5'd31);
        repeat (3) tick();
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("expiry_freeze", {rd_addr, wrap}, {5'd31, 1'b0});
        end
        enable = 1'b1;
        repeat (4) tick();
        chk("resume_addr31", {rd_addr, wrap}, {5'd31, 1'b0});
        tick();
        chk("resume_wrap", {rd_addr, wrap}, {5'd0, 1'b1});
        tick();
        chk("resume_wrap_end", {rd_addr, wrap}, {5'd0, 1'b0});

        // Asynchronous reset in the ISSUE cycle of address 9.
        wait_rd(5'd9);
        reset = 1'b1;
        #1;
        chk("async_reset", cur(), pack(0, 0, 0, 0, 0));
        tick();
        tick();
        chk("reset_held", cur(), pack(0, 0, 0, 0, 0));
        run_table();

`ifdef RAM_SCAN_READER_STEP_EN
        wait_rd(5'd31);
        tick();
        tick();
        enable = 1'b0;
        repeat (3) tick();
        chk("step_pre", cur(), pack(31, 31, 7, 1, 0));
        step = 1'b1;
        tick();
        chk("step_wrap", {rd_addr, wrap}, {5'd0, 1'b1});
        step = 1'b0;
        tick();
        chk("step_wrap_end", 32'(wrap), 32'd0);
        tick();
        chk("step_capture", cur(), pack(0, 0, 0, 1, 0));
        repeat (6) tick();
        chk("step_idle", cur(), pack(0, 0, 0, 1, 0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
